// File: rtl/temp_calc_sequencer_if.sv
// Handshake bundle between the ADC sample source, the temperature calculator and
// the temperature consumer. The master modport is the source/consumer side; the
// slave modport is the calculator.
interface temp_calc_sequencer_if #(
  parameter int unsigned BASE_W = 32,
  parameter int unsigned REF_W  = 8,
  parameter int unsigned ADC_W  = 16
);

  logic [BASE_W-1:0] tc_base;
  logic [REF_W-1:0]  tc_ref;
  logic [ADC_W-1:0]  adc_data;
  logic              in_valid;
  logic              in_ready;
  logic [BASE_W-1:0] tempc;
  logic              tempc_ovf;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [15:0]       sample_count;

  modport master (
    output tc_base,
    output tc_ref,
    output adc_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  tempc,
    input  tempc_ovf,
    input  out_valid,
    input  busy,
    input  sample_count
  );

  modport slave (
    input  tc_base,
    input  tc_ref,
    input  adc_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output tempc,
    output tempc_ovf,
    output out_valid,
    output busy,
    output sample_count
  );

endinterface

// File: rtl/temp_calc_sequencer.sv
// Sequential temperature calculator: tempc = tc_base + tc_ref * adc_data.
// Operands are latched at the input handshake, the product is built by a serial
// shift-add (one multiplier bit per cycle, fixed latency), then a single add
// produces the registered result, which is held until the consumer takes it.
module temp_calc_sequencer #(
  parameter int unsigned BASE_W = 32,
  parameter int unsigned REF_W  = 8,
  parameter int unsigned ADC_W  = 16
) (
  input logic                    clk,
  input logic                    rst,
  temp_calc_sequencer_if.slave   bus
);

  localparam int unsigned AccW = REF_W + ADC_W;
  localparam int unsigned CntW = (ADC_W > 1) ? $clog2(ADC_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StAdd,
    StDone
  } state_e;

  state_e            state_q;
  logic [BASE_W-1:0] base_q;
  logic [REF_W-1:0]  ref_q;
  logic [ADC_W-1:0]  adc_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [BASE_W-1:0] tempc_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;
  logic [15:0]       count_q;

  logic [AccW-1:0]   partial;
  logic [BASE_W:0]   sum;
  logic              last_bit;

  // Partial product for the current multiplier bit and the final carry-out add.
  always_comb begin
    partial = '0;
    if (adc_q[cnt_q]) begin
      partial = AccW'(ref_q) << cnt_q;
    end
    sum      = {1'b0, base_q} + (BASE_W + 1)'(acc_q);
    last_bit = (cnt_q == CntW'(ADC_W - 1));
  end

  // Control FSM and datapath registers; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      ref_q       <= '0;
      adc_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      tempc_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            base_q     <= bus.tc_base;
            ref_q      <= bus.tc_ref;
            adc_q      <= bus.adc_data;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StMul;
          end
        end
        StMul: begin
          // Always walk all ADC_W bits so latency never depends on the data.
          acc_q <= acc_q + partial;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            state_q <= StAdd;
          end
        end
        StAdd: begin
          tempc_q     <= sum[BASE_W-1:0];
          ovf_q       <= sum[BASE_W];
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          // tempc/tempc_ovf deliberately keep their value after the handshake.
          if (bus.out_ready && out_valid_q) begin
            out_valid_q <= 1'b0;
            count_q     <= count_q + 16'd1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.tempc        = tempc_q;
  assign bus.tempc_ovf    = ovf_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_temp_calc_sequencer.sv
// Bench for temp_calc_sequencer: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_temp_calc_sequencer;

  localparam int unsigned BASE_W = 32;
  localparam int unsigned REF_W  = 8;
  localparam int unsigned ADC_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_calc_sequencer_if #(.BASE_W(BASE_W), .REF_W(REF_W), .ADC_W(ADC_W)) bus ();

  temp_calc_sequencer #(.BASE_W(BASE_W), .REF_W(REF_W), .ADC_W(ADC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sample is taken whenever the block is idle, its result
  // appears ADC_W+1 edges later and stays until the consumer accepts it.
  bit          m_idle  = 1'b1;
  bit          m_ov    = 1'b0;
  int          m_left  = 0;
  logic [32:0] m_res   = '0;
  logic [31:0] m_tempc = '0;
  bit          m_ovf   = 1'b0;
  logic [15:0] m_cnt   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle  = 1'b1;
      m_ov    = 1'b0;
      m_left  = 0;
      m_tempc = '0;
      m_ovf   = 1'b0;
      m_cnt   = '0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle = 1'b0;
        m_left = ADC_W + 1;
        m_res  = 33'(bus.tc_base) + 33'(bus.tc_ref) * 33'(bus.adc_data);
      end
    end else if (m_ov) begin
      if (bus.out_ready) begin
        m_ov   = 1'b0;
        m_idle = 1'b1;
        m_cnt  = m_cnt + 16'd1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_ov    = 1'b1;
        m_tempc = m_res[31:0];
        m_ovf   = m_res[32];
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_idle));
      check("busy", 64'(bus.busy), 64'(!m_idle));
      check("out_valid", 64'(bus.out_valid), 64'(m_ov));
      check("sample_count", 64'(bus.sample_count), 64'(m_cnt));
      check("tempc", 64'(bus.tempc), 64'(m_tempc));
      check("tempc_ovf", 64'(bus.tempc_ovf), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] b, input logic [7:0] r, input logic [15:0] a,
                       input logic v, input logic o);
    bus.tc_base   = b;
    bus.tc_ref    = r;
    bus.adc_data  = a;
    bus.in_valid  = v;
    bus.out_ready = o;
  endtask

  // Edges from the input handshake until out_valid is seen; bounded.
  task automatic wait_ov(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=none required=out_valid within 60 cycles");
    end
  endtask

  initial begin
    int lat;
    bit seen;
    int hs[$];

    drive(32'd0, 8'd0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;

    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_tempc", 64'(bus.tempc), 64'd0);
    check("rst_count", 64'(bus.sample_count), 64'd0);

    // Basic
    drive(32'd100, 8'd3, 16'd1000, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_ov(lat);
    check("basic_latency", 64'(lat), 64'd17);
    check("basic_tempc", 64'(bus.tempc), 64'd3100);
    check("basic_ovf", 64'(bus.tempc_ovf), 64'd0);
    tick();
    check("basic_count", 64'(bus.sample_count), 64'd1);
    check("basic_in_ready", 64'(bus.in_ready), 64'd1);

    // Operand isolation: inputs change mid-multiply
    drive(32'd100, 8'd3, 16'd1000, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.tc_base  = 32'd5000;
    bus.adc_data = 16'd7;
    wait_ov(lat);
    check("iso_tempc", 64'(bus.tempc), 64'd3100);
    tick();

    // Max product
    drive(32'hFF000000, 8'd255, 16'hFFFF, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_ov(lat);
    check("max_tempc", 64'(bus.tempc), 64'hFFFEFF01);
    check("max_ovf", 64'(bus.tempc_ovf), 64'd0);
    tick();

    // Carry out of the final add
    drive(32'hFFFFFFFF, 8'd1, 16'd1, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    wait_ov(lat);
    check("carry_tempc", 64'(bus.tempc), 64'd0);
    check("carry_ovf", 64'(bus.tempc_ovf), 64'd1);
    tick();
    check("count_after4", 64'(bus.sample_count), 64'd4);

    // Backpressure with a new sample waiting
    drive(32'd100, 8'd3, 16'd1000, 1'b1, 1'b0);
    tick();
    bus.adc_data = 16'd2000;
    wait_ov(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_tempc", 64'(bus.tempc), 64'd3100);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_busy", 64'(bus.busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_idle_count", 64'(bus.sample_count), 64'd5);
    tick();
    check("bp_accept_busy", 64'(bus.busy), 64'd1);
    bus.in_valid = 1'b0;
    wait_ov(lat);
    check("bp_new_tempc", 64'(bus.tempc), 64'd6100);
    tick();

    // Reset in the middle of the multiply
    drive(32'd100, 8'd3, 16'd1000, 1'b1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_count", 64'(bus.sample_count), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("mrst_no_out_valid", 64'(seen), 64'd0);

    // Streaming: three back-to-back samples
    drive(32'd7, 8'd11, 16'd13, 1'b1, 1'b1);
    for (int i = 0; i < 80 && hs.size() < 3; i++) begin
      if (bus.in_ready && bus.in_valid) hs.push_back(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_handshakes", 64'(hs.size()), 64'd3);
    if (hs.size() == 3) begin
      check("stream_gap1", 64'(hs[1] - hs[0]), 64'd19);
      check("stream_gap2", 64'(hs[2] - hs[1]), 64'd19);
    end
    wait_ov(lat);
    check("stream_tempc", 64'(bus.tempc), 64'd150);
    tick();
    check("stream_count", 64'(bus.sample_count), 64'd3);

    // Randomized traffic, backpressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.tc_base   = $urandom;
      bus.tc_ref    = 8'($urandom);
      bus.adc_data  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (25) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
